// File: rtl/tristate_pkg.sv
// Shared definitions for the tri-state output driver.
package tristate_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned MAX_WIDTH     = 64;

  // Released-bus value. Callers keep only the low bits they need.
  function automatic logic [MAX_WIDTH-1:0] all_z(input int unsigned width);
    logic [MAX_WIDTH-1:0] v;
    v = {MAX_WIDTH{1'bz}};
    if (width == 0) v = '0;
    return v;
  endfunction

endpackage

// File: rtl/tristate_buffer_reg.sv
// Output-register stage: captures data and enable on clk, async clear to a released state.
module tristate_buffer_reg
  import tristate_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_a,
  output logic             o_en
);

  logic [WIDTH-1:0] r_a;
  logic             r_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_en <= 1'b0;
    end else begin
      r_a  <= i_a;
      r_en <= i_en;
    end
  end

  assign o_a  = r_a;
  assign o_en = r_en;

endmodule

// File: rtl/tristate_buffer.sv
// Tri-state output driver with optional registered a/en path; reset always releases the bus.
module tristate_buffer
  import tristate_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  output wire logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic             drive_on
);

  logic [WIDTH-1:0] w_data;
  logic             w_drive;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] w_a_q;
    logic             w_en_q;

    tristate_buffer_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_a   (a),
      .i_en  (en),
      .o_a   (w_a_q),
      .o_en  (w_en_q)
    );

    assign w_data  = w_a_q;
    assign w_drive = w_en_q;
  end else begin : g_comb
    logic w_unused_clk;
    assign w_unused_clk = clk;

    // Reset gates the enable directly so the bus is released with no clock.
    assign w_data  = a;
    assign w_drive = en & rst_n;
  end

  assign drive_on = w_drive;

  // An X/Z enable merges data with 'z, giving 'x on b in simulation.
  assign b = w_drive ? w_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_buffer.sv
// Directed bench for tristate_buffer: combinational, registered, wide and shared-bus instances.
module tb_tristate_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_c, rst_r;

  // Each bus net also has a bench probe driver; when the DUT releases the net, the probe
  // value must show through, and any stray DUT drive corrupts it.
  logic en_c, a_c, do_c, pc_en, pc_val;
  wire  b_c;
  assign b_c = pc_en ? pc_val : 1'bz;

  logic en_r, a_r, do_r, pr_en, pr_val;
  wire  b_r;
  assign b_r = pr_en ? pr_val : 1'bz;

  logic       en_w, do_w, pw_en;
  logic [7:0] a_w, pw_val;
  wire  [7:0] b_w;
  assign b_w = pw_en ? pw_val : 8'bz;

  logic       en0, en1, do0, do1, ps_en;
  logic [7:0] a0, a1, ps_val;
  wire  [7:0] bus_s;
  assign bus_s = ps_en ? ps_val : 8'bz;

  tristate_buffer #(.WIDTH(1), .REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_c), .b(b_c), .a(a_c), .en(en_c), .drive_on(do_c)
  );

  tristate_buffer #(.WIDTH(1), .REG_OUT(1'b1)) u_regd (
    .clk(clk), .rst_n(rst_r), .b(b_r), .a(a_r), .en(en_r), .drive_on(do_r)
  );

  tristate_buffer #(.WIDTH(8), .REG_OUT(1'b0)) u_w8 (
    .clk(clk), .rst_n(rst_c), .b(b_w), .a(a_w), .en(en_w), .drive_on(do_w)
  );

  tristate_buffer #(.WIDTH(8), .REG_OUT(1'b0)) u_bus0 (
    .clk(clk), .rst_n(rst_c), .b(bus_s), .a(a0), .en(en0), .drive_on(do0)
  );

  tristate_buffer #(.WIDTH(8), .REG_OUT(1'b0)) u_bus1 (
    .clk(clk), .rst_n(rst_c), .b(bus_s), .a(a1), .en(en1), .drive_on(do1)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
    else n_pass++;
  endtask

  initial begin
    rst_c = 1'b0; rst_r = 1'b0;
    en_c = 1'b0; a_c = 1'b0; pc_en = 1'b1; pc_val = 1'b0;
    en_r = 1'b0; a_r = 1'b0; pr_en = 1'b1; pr_val = 1'b0;
    en_w = 1'b0; a_w = 8'h00; pw_en = 1'b1; pw_val = 8'h00;
    en0 = 1'b0; en1 = 1'b0; a0 = 8'hA5; a1 = 8'h5A; ps_en = 1'b1; ps_val = 8'h00;
    #1;
    check("rst_comb_drive_on", do_c, 1'b0);
    check("rst_reg_drive_on", do_r, 1'b0);
    check("rst_reg_b_released", b_r, 1'b0);

    // Combinational path
    rst_c = 1'b1;
    a_c = 1'b1; en_c = 1'b0; pc_val = 1'b0; #1;
    check("comb_off_b_released", b_c, 1'b0);
    check("comb_off_drive_on", do_c, 1'b0);
    pc_en = 1'b0; en_c = 1'b1; #1;
    check("comb_en_a1_b", b_c, 1'b1);
    check("comb_en_drive_on", do_c, 1'b1);
    a_c = 1'b0; #1;
    check("comb_en_a0_b", b_c, 1'b0);

    // Reset overrides enable on the combinational path
    rst_c = 1'b0; a_c = 1'b1; en_c = 1'b1; pc_en = 1'b1; pc_val = 1'b0; #1;
    check("comb_rst_b_released", b_c, 1'b0);
    check("comb_rst_drive_on", do_c, 1'b0);
    rst_c = 1'b1; pc_en = 1'b0; #1;
    check("comb_rst_release_b", b_c, 1'b1);
    check("comb_rst_release_drive_on", do_c, 1'b1);

    // Registered path: one-cycle latency
    @(negedge clk); rst_r = 1'b1;
    @(negedge clk); en_r = 1'b1; a_r = 1'b1; #1;
    check("reg_before_edge_drive_on", do_r, 1'b0);
    check("reg_before_edge_b_released", b_r, 1'b0);
    @(posedge clk); pr_en = 1'b0; #1;
    check("reg_after_edge_b", b_r, 1'b1);
    check("reg_after_edge_drive_on", do_r, 1'b1);
    @(negedge clk); en_r = 1'b0; #1;
    check("reg_en_low_still_driving", do_r, 1'b1);
    @(posedge clk); #1; pr_en = 1'b1; pr_val = 1'b0; #1;
    check("reg_off_b_released", b_r, 1'b0);
    check("reg_off_drive_on", do_r, 1'b0);

    // Registered path: asynchronous reset mid-cycle
    @(negedge clk); en_r = 1'b1; a_r = 1'b1; pr_en = 1'b0;
    @(posedge clk); #1;
    check("reg_redrive_b", b_r, 1'b1);
    #1; rst_r = 1'b0; pr_en = 1'b1; pr_val = 1'b0; #1;
    check("reg_async_rst_b_released", b_r, 1'b0);
    check("reg_async_rst_drive_on", do_r, 1'b0);
    rst_r = 1'b1; #1;
    check("reg_rst_release_waits_edge", do_r, 1'b0);
    @(posedge clk); pr_en = 1'b0; #1;
    check("reg_first_capture_b", b_r, 1'b1);
    check("reg_first_capture_drive_on", do_r, 1'b1);

    // Eight-bit instance
    pw_en = 1'b0; en_w = 1'b1; a_w = 8'hA5; #1;
    check("w8_en_b", b_w, 8'hA5);
    check("w8_en_drive_on", do_w, 1'b1);
    en_w = 1'b0; pw_en = 1'b1; pw_val = 8'h00; #1;
    check("w8_off_b_released", b_w, 8'h00);
    check("w8_off_drive_on", do_w, 1'b0);

    // Two drivers sharing one bus
    ps_en = 1'b0; en0 = 1'b1; en1 = 1'b0; #1;
    check("bus_inst0_b", bus_s, 8'hA5);
    check("bus_inst0_do1", do1, 1'b0);
    en0 = 1'b0; en1 = 1'b1; #1;
    check("bus_inst1_b", bus_s, 8'h5A);
    check("bus_inst1_do0", do0, 1'b0);
    en1 = 1'b0; ps_en = 1'b1; ps_val = 8'h00; #1;
    check("bus_both_off_b", bus_s, 8'h00);
    check("bus_both_off_do", {do0, do1}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
